writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_queue : in-order write-result FIFO feeding a registered
// register-file write port, with pending-write scoreboard and forwarding.
// Revision: 1.0
// ---------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_reg,
  input  logic [DW-1:0]              in_data,
  input  logic                       wb_stall,
  output logic                       wb_reg_write,
  output logic [4:0]                 wb_reg_num,
  output logic [DW-1:0]              wb_data,
  input  logic [4:0]                 fwd_num_1,
  input  logic [4:0]                 fwd_num_2,
  output logic                       fwd_hit_1,
  output logic                       fwd_hit_2,
  output logic [DW-1:0]              fwd_data_1,
  output logic [DW-1:0]              fwd_data_2,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_reg_q  [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_reg_write_q;
  logic [4:0]    wb_reg_num_q;
  logic [DW-1:0] wb_data_q;

  logic push, pop;

  // A handshake to r0 completes but is dropped before reaching storage.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_reg != 5'd0);
  assign pop      = (count_q != '0) && !wb_stall;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + AW'(1);
    if (pop)  head_d = head_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_reg_num_q   <= '0;
      wb_data_q      <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      wb_reg_write_q <= pop;
      if (pop) begin
        wb_reg_num_q <= mem_reg_q[head_q];
        wb_data_q    <= mem_data_q[head_q];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (tail_q == AW'(i))) begin
          mem_reg_q[i]  <= in_reg;
          mem_data_q[i] <= in_data;
        end
      end
    end
  endgenerate

  logic [31:0]   pend;
  logic [DW-1:0] match_1, match_2;
  logic [AW-1:0] idx;

  // Scan oldest to youngest so the tail-most match overrides the wb stage.
  always_comb begin
    pend    = '0;
    match_1 = '0;
    match_2 = '0;
    idx     = '0;
    if (wb_reg_write_q) begin
      pend[wb_reg_num_q] = 1'b1;
      if (wb_reg_num_q == fwd_num_1) match_1 = wb_data_q;
      if (wb_reg_num_q == fwd_num_2) match_2 = wb_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (CW'(k) < count_q) begin
        pend[mem_reg_q[idx]] = 1'b1;
        if (mem_reg_q[idx] == fwd_num_1) match_1 = mem_data_q[idx];
        if (mem_reg_q[idx] == fwd_num_2) match_2 = mem_data_q[idx];
      end
    end
    pend[0] = 1'b0;
  end

  assign pending    = pend;
  assign fwd_hit_1  = (fwd_num_1 != 5'd0) && pend[fwd_num_1];
  assign fwd_hit_2  = (fwd_num_2 != 5'd0) && pend[fwd_num_2];
  assign fwd_data_1 = fwd_hit_1 ? match_1 : '0;
  assign fwd_data_2 = fwd_hit_2 ? match_2 : '0;

  assign wb_reg_write = wb_reg_write_q;
  assign wb_reg_num   = wb_reg_num_q;
  assign wb_data      = wb_data_q;
  assign count        = count_q;

endmodule
`default_nettype wire
